color_palette: RTL and testbench

- Parametrised, pipelined successor to the fixed iteration-to-RGB colour map.
- Converts a per-pixel escape-iteration count into RGB through a runtime-writable palette register file.
- Supports palette rotation (colour cycling) driven by frame ticks, a dedicated in-set colour, and valid/ready flow control.
- Sits between the Mandelbrot iteration engine output and the pixel/framebuffer writer.

---
 rtl/color_palette_if.sv | 39 +++
 rtl/color_palette.sv | 100 ++++++++++
 tb/tb_color_palette.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_palette_if.sv
// Pixel stream, palette write port and colour-cycling controls of the colour palette stage.
// The master drives pixels/controls in; the slave is the palette block itself.
interface color_palette_if #(
  parameter int ITER_W  = 5,
  parameter int COLOR_W = 8,
  parameter int DIV_W   = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ITER_W-1:0]      in_iter;
  logic                   in_inset;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLOR_W-1:0]     out_red;
  logic [COLOR_W-1:0]     out_green;
  logic [COLOR_W-1:0]     out_blue;
  logic                   wr_en;
  logic [ITER_W-1:0]      wr_addr;
  logic [3*COLOR_W-1:0]   wr_data;
  logic                   frame_tick;
  logic                   cycle_en;
  logic                   cycle_dir;
  logic [DIV_W-1:0]       cycle_div;
  logic [ITER_W-1:0]      offset;

  modport master (
    output in_valid, in_iter, in_inset, out_ready,
    output wr_en, wr_addr, wr_data,
    output frame_tick, cycle_en, cycle_dir, cycle_div,
    input  in_ready, out_valid, out_red, out_green, out_blue, offset
  );

  modport slave (
    input  in_valid, in_iter, in_inset, out_ready,
    input  wr_en, wr_addr, wr_data,
    input  frame_tick, cycle_en, cycle_dir, cycle_div,
    output in_ready, out_valid, out_red, out_green, out_blue, offset
  );
endinterface

// File: rtl/color_palette.sv
// Iteration-count to RGB mapper: two-stage valid/ready pipeline (index, colour) over a
// runtime-writable palette, with frame-tick driven palette rotation.
module color_palette #(
  parameter int                     ITER_W    = 5,
  parameter int                     COLOR_W   = 8,
  parameter logic [3*COLOR_W-1:0]   INSET_RGB = 24'h000000,
  parameter int                     DIV_W     = 8
) (
  input logic             clk,
  input logic             rst_n,
  color_palette_if.slave  bus_io
);
  localparam int DEPTH = 1 << ITER_W;
  localparam int SHIFT = COLOR_W - ITER_W;
  localparam int RGB_W = 3 * COLOR_W;

  function automatic logic [RGB_W-1:0] grey(input int k);
    logic [COLOR_W-1:0] c;
    c = COLOR_W'(k) << SHIFT;
    return {c, c, c};
  endfunction

  logic [RGB_W-1:0]  pal_q [DEPTH];

  logic              v1_q;
  logic [ITER_W-1:0] idx1_q, idx1_d;
  logic              inset1_q;

  logic              v2_q;
  logic [RGB_W-1:0]  rgb2_q, rgb2_d;

  logic [ITER_W-1:0] off_q, off_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;

  logic              en1, en2;

  // Stall propagates backwards: a stage may load when it is empty or its successor moves.
  always_comb begin
    en2    = !v2_q || bus_io.out_ready;
    en1    = !v1_q || en2;
    idx1_d = bus_io.in_iter + off_q;
    rgb2_d = inset1_q ? INSET_RGB : pal_q[idx1_q];
    cnt_d  = cnt_q;
    off_d  = off_q;
    if (bus_io.frame_tick && bus_io.cycle_en) begin
      if (cnt_q >= bus_io.cycle_div) begin
        cnt_d = '0;
        off_d = bus_io.cycle_dir ? off_q - ITER_W'(1) : off_q + ITER_W'(1);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        pal_q[k] <= grey(k);
      end
    end else if (bus_io.wr_en) begin
      pal_q[bus_io.wr_addr] <= bus_io.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      idx1_q   <= '0;
      inset1_q <= 1'b0;
      v2_q     <= 1'b0;
      rgb2_q   <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
    end else begin
      off_q <= off_d;
      cnt_q <= cnt_d;
      if (en1) begin
        v1_q <= bus_io.in_valid;
        if (bus_io.in_valid) begin
          idx1_q   <= idx1_d;
          inset1_q <= bus_io.in_inset;
        end
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          rgb2_q <= rgb2_d;
        end
      end
    end
  end

  assign bus_io.in_ready  = en1;
  assign bus_io.out_valid = v2_q;
  assign bus_io.out_red   = rgb2_q[RGB_W-1 -: COLOR_W];
  assign bus_io.out_green = rgb2_q[2*COLOR_W-1 -: COLOR_W];
  assign bus_io.out_blue  = rgb2_q[COLOR_W-1:0];
  assign bus_io.offset    = off_q;

endmodule

// File: tb/tb_color_palette.sv
// Scoreboard bench for color_palette: expected colours are queued at input accept from a
// bench-side palette/offset model and popped when the output handshake fires.
module tb_color_palette;
  localparam int ITER_W  = 5;
  localparam int COLOR_W = 8;
  localparam int DIV_W   = 8;
  localparam int DEPTH   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  color_palette_if #(.ITER_W(ITER_W), .COLOR_W(COLOR_W), .DIV_W(DIV_W)) bus ();

  color_palette #(
    .ITER_W(ITER_W), .COLOR_W(COLOR_W), .INSET_RGB(24'h000000), .DIV_W(DIV_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_io(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] model_pal [DEPTH];
  int          model_off;
  int          model_cnt;
  logic [23:0] sb [$];

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) model_pal[k] = {3{8'(k * 8)}};
    model_off = 0;
    model_cnt = 0;
    sb.delete();
  endfunction

  function automatic void idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_iter    = '0;
    bus.in_inset   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.frame_tick = 1'b0;
    bus.cycle_en   = 1'b0;
    bus.cycle_dir  = 1'b0;
    bus.cycle_div  = '0;
  endfunction

  // One clock: sample handshakes before the edge, advance, then update the model.
  task automatic step(output bit acc, output bit fire, output logic [23:0] got, output logic [23:0] exp);
    acc  = bus.in_valid && bus.in_ready;
    fire = bus.out_valid && bus.out_ready;
    got  = {bus.out_red, bus.out_green, bus.out_blue};
    exp  = 'x;
    if (acc) sb.push_back(bus.in_inset ? 24'h000000 : model_pal[(int'(bus.in_iter) + model_off) % DEPTH]);
    if (fire && sb.size() > 0) exp = sb.pop_front();
    @(posedge clk); #1;
    if (bus.wr_en) model_pal[bus.wr_addr] = bus.wr_data;
    if (bus.frame_tick && bus.cycle_en) begin
      if (model_cnt >= int'(bus.cycle_div)) begin
        model_cnt = 0;
        model_off = bus.cycle_dir ? (model_off + DEPTH - 1) % DEPTH : (model_off + 1) % DEPTH;
      end else begin
        model_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.offset !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_offset got %0d want 0", bus.offset); end
    vectors++;
    if ({bus.out_red, bus.out_green, bus.out_blue} !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL reset_rgb got %h want 000000", {bus.out_red, bus.out_green, bus.out_blue});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_ramp();
    logic [ITER_W-1:0] iters [3] = '{5'd3, 5'd31, 5'd0};
    logic [23:0]       want  [3] = '{24'h181818, 24'hF8F8F8, 24'h000000};
    bit acc, fire;
    logic [23:0] got, exp;
    int sent = 0;
    int nfire = 0;
    int first = -1;
    bus.cycle_en  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_inset  = 1'b0;
    for (int c = 0; c < 20 && nfire < 3; c++) begin
      bus.in_valid = (sent < 3);
      bus.in_iter  = iters[sent < 3 ? sent : 0];
      step(acc, fire, got, exp);
      if (acc) begin
        if (first < 0) first = c;
        sent++;
      end
      if (fire) begin
        vectors++;
        if (got !== exp || got !== want[nfire]) begin
          miscompares++;
          $display("[TB] FAIL ramp_rgb[%0d] got %h want %h", nfire, got, want[nfire]);
        end
        vectors++;
        if (c - first != nfire + 2) begin
          miscompares++;
          $display("[TB] FAIL ramp_latency[%0d] got cycle %0d want %0d", nfire, c - first, nfire + 2);
        end
        nfire++;
      end
    end
    bus.in_valid = 1'b0;
    vectors++; if (nfire != 3) begin miscompares++; $display("[TB] FAIL ramp_count got %0d want 3", nfire); end
  endtask

  task automatic test_inset();
    logic [ITER_W-1:0] iters  [2] = '{5'd17, 5'd17};
    logic              insets [2] = '{1'b1, 1'b0};
    logic [23:0]       want   [2] = '{24'h000000, 24'h888888};
    bit acc, fire;
    logic [23:0] got, exp;
    int sent = 0;
    int nfire = 0;
    for (int c = 0; c < 20 && nfire < 2; c++) begin
      bus.in_valid = (sent < 2);
      bus.in_iter  = iters[sent < 2 ? sent : 0];
      bus.in_inset = insets[sent < 2 ? sent : 0];
      step(acc, fire, got, exp);
      if (acc) sent++;
      if (fire) begin
        vectors++;
        if (got !== exp || got !== want[nfire]) begin
          miscompares++;
          $display("[TB] FAIL inset_rgb[%0d] got %h want %h", nfire, got, want[nfire]);
        end
        nfire++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_inset = 1'b0;
    vectors++; if (nfire != 2) begin miscompares++; $display("[TB] FAIL inset_count got %0d want 2", nfire); end
  endtask

  task automatic test_palette_write();
    bit acc, fire;
    logic [23:0] got, exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_iter   = 5'd5;
    step(acc, fire, got, exp);
    vectors++; if (!acc) begin miscompares++; $display("[TB] FAIL wr_accept got %b want 1", acc); end
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = {8'd255, 8'd170, 8'd0};
    step(acc, fire, got, exp);
    bus.wr_en = 1'b0;
    step(acc, fire, got, exp);
    vectors++;
    if (!fire || got !== exp || got !== 24'h282828) begin
      miscompares++;
      $display("[TB] FAIL wr_collision_old got %h fire %b want 282828", got, fire);
    end
    bus.in_valid = 1'b1;
    step(acc, fire, got, exp);
    bus.in_valid = 1'b0;
    step(acc, fire, got, exp);
    step(acc, fire, got, exp);
    vectors++;
    if (!fire || got !== exp || got !== 24'hFFAA00) begin
      miscompares++;
      $display("[TB] FAIL wr_new_value got %h fire %b want ffaa00", got, fire);
    end
  endtask

  task automatic tick_once();
    bit acc, fire;
    logic [23:0] got, exp;
    bus.frame_tick = 1'b1;
    step(acc, fire, got, exp);
    bus.frame_tick = 1'b0;
    step(acc, fire, got, exp);
  endtask

  task automatic test_cycling();
    bit acc, fire;
    logic [23:0] got, exp;
    bus.cycle_en  = 1'b1;
    bus.cycle_div = 8'd2;
    bus.cycle_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_once();
      vectors++;
      if (bus.offset !== ITER_W'(model_off)) begin
        miscompares++;
        $display("[TB] FAIL cyc_div2_tick%0d got %0d want %0d", i, bus.offset, model_off);
      end
    end
    vectors++; if (bus.offset !== 5'd1) begin miscompares++; $display("[TB] FAIL cyc_offset1 got %0d want 1", bus.offset); end
    bus.in_valid = 1'b1;
    bus.in_iter  = 5'd31;
    step(acc, fire, got, exp);
    bus.in_valid = 1'b0;
    step(acc, fire, got, exp);
    step(acc, fire, got, exp);
    vectors++;
    if (!fire || got !== exp || got !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL cyc_wrap_index got %h fire %b want 000000", got, fire);
    end
    bus.cycle_dir = 1'b1;
    bus.cycle_div = 8'd0;
    tick_once();
    vectors++; if (bus.offset !== 5'd0) begin miscompares++; $display("[TB] FAIL cyc_down0 got %0d want 0", bus.offset); end
    tick_once();
    vectors++; if (bus.offset !== 5'd31) begin miscompares++; $display("[TB] FAIL cyc_down_wrap got %0d want 31", bus.offset); end
    bus.cycle_en = 1'b0;
    tick_once();
    tick_once();
    vectors++; if (bus.offset !== 5'd31) begin miscompares++; $display("[TB] FAIL cyc_freeze got %0d want 31", bus.offset); end
    bus.cycle_en  = 1'b1;
    bus.cycle_dir = 1'b0;
    bus.cycle_div = 8'd3;
    tick_once();
    tick_once();
    vectors++; if (bus.offset !== 5'd31) begin miscompares++; $display("[TB] FAIL cyc_counting got %0d want 31", bus.offset); end
    bus.cycle_div = 8'd1;
    tick_once();
    vectors++; if (bus.offset !== 5'd0) begin miscompares++; $display("[TB] FAIL cyc_div_shrink got %0d want 0", bus.offset); end
    bus.cycle_div  = 8'd0;
    bus.in_valid   = 1'b1;
    bus.in_iter    = 5'd0;
    bus.frame_tick = 1'b1;
    step(acc, fire, got, exp);
    bus.in_valid   = 1'b0;
    bus.frame_tick = 1'b0;
    vectors++; if (bus.offset !== 5'd1) begin miscompares++; $display("[TB] FAIL cyc_simul_offset got %0d want 1", bus.offset); end
    step(acc, fire, got, exp);
    step(acc, fire, got, exp);
    vectors++;
    if (!fire || got !== exp || got !== 24'h000000) begin
      miscompares++;
      $display("[TB] FAIL cyc_simul_pre_step got %h fire %b want 000000", got, fire);
    end
    bus.cycle_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit acc, fire;
    logic [23:0] got, exp, held;
    int naccept = 0;
    int nfire = 0;
    bit have_held = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_iter = ITER_W'(10 + 3 * c);
      step(acc, fire, got, exp);
      if (acc) naccept++;
      if (bus.out_valid) begin
        if (!have_held) begin
          held = {bus.out_red, bus.out_green, bus.out_blue};
          have_held = 1'b1;
        end else begin
          vectors++;
          if ({bus.out_red, bus.out_green, bus.out_blue} !== held) begin
            miscompares++;
            $display("[TB] FAIL stall_stable got %h want %h", {bus.out_red, bus.out_green, bus.out_blue}, held);
          end
        end
      end
    end
    vectors++; if (naccept != 2) begin miscompares++; $display("[TB] FAIL stall_accepts got %0d want 2", naccept); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_out_valid got %b want 1", bus.out_valid); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && nfire < 2; c++) begin
      step(acc, fire, got, exp);
      if (fire) begin
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL drain_order[%0d] got %h want %h", nfire, got, exp);
        end
        nfire++;
      end
    end
    vectors++; if (nfire != 2) begin miscompares++; $display("[TB] FAIL drain_count got %0d want 2", nfire); end
    step(acc, fire, got, exp);
    vectors++; if (fire || sb.size() != 0) begin miscompares++; $display("[TB] FAIL drain_extra got fire %b queue %0d want 0", fire, sb.size()); end
  endtask

  task automatic test_reset_midflight();
    bit acc, fire;
    logic [23:0] got, exp;
    bus.cycle_en  = 1'b1;
    bus.cycle_div = 8'd0;
    bus.cycle_dir = 1'b0;
    for (int i = 0; i < 40 && model_off != 7; i++) tick_once();
    bus.cycle_en = 1'b0;
    vectors++; if (bus.offset !== 5'd7) begin miscompares++; $display("[TB] FAIL mid_offset7 got %0d want 7", bus.offset); end
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 24'h123456;
    step(acc, fire, got, exp);
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_iter   = 5'd2;
    step(acc, fire, got, exp);
    step(acc, fire, got, exp);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.offset !== 5'd0) begin miscompares++; $display("[TB] FAIL mid_offset got %0d want 0", bus.offset); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_iter   = 5'd5;
    step(acc, fire, got, exp);
    bus.in_valid = 1'b0;
    step(acc, fire, got, exp);
    vectors++; if (!fire && bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_no_stale got out_valid %b want 1", bus.out_valid); end
    step(acc, fire, got, exp);
    vectors++;
    if (!fire || got !== exp || got !== 24'h282828) begin
      miscompares++;
      $display("[TB] FAIL mid_palette_restored got %h fire %b want 282828", got, fire);
    end
    step(acc, fire, got, exp);
    vectors++; if (fire) begin miscompares++; $display("[TB] FAIL mid_discarded got extra pixel %h want none", got); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp();
    test_inset();
    test_palette_write();
    test_cycling();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
